stream_packet_arbiter: RTL
==========================

// Module: stream_packet_arbiter
// PURPOSE
//  Shares one downstream stream consumer between two upstream producers, A and B.
//  It arbitrates at packet granularity and locks onto the granted input until its
//  'last' element transfers. Alternation is round-robin.
//  It sits in front of stream_splitter and other next_data/valid/last sinks.
//  It also polices packet length: over-long packets are cut and flagged.
// PARAMETERS
//  WIDTH           5   data width of all streams
//  MAX_PACKET_LEN  8   max elements per packet; >=2
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      sync active-high reset
//  ds_in_a_next_data   out  1      ready to producer A
//  ds_in_a             in   WIDTH  producer A data
//  ds_in_a_valid       in   1      producer A data valid
//  ds_in_a_last        in   1      producer A last element of packet
//  ds_in_b_next_data   out  1      ready to producer B
//  ds_in_b             in   WIDTH  producer B data
//  ds_in_b_valid       in   1      producer B data valid
//  ds_in_b_last        in   1      producer B last element of packet
//  ds_out_next_data    in   1      downstream ready
//  ds_out              out  WIDTH  arbitrated data
//  ds_out_valid        out  1      arbitrated valid
//  ds_out_last         out  1      arbitrated last (input last OR forced cut)
//  ds_out_source       out  1      0=A, 1=B; meaningful while ds_out_valid
//  err_overlong        out  1      sticky: a packet was cut at MAX_PACKET_LEN
// BEHAVIOUR
//  Transfer: a side's valid & next_data are both high at a rising clk edge.
//  FSM states are IDLE, GRANT_A and GRANT_B.
//  - IDLE: all next_data=0; ds_out_valid=0.
//    - Only A valid -> GRANT_A. Only B valid -> GRANT_B.
//    - Both valid -> grant the input != last_grant.
//    - Neither valid -> stay in IDLE.
//  - GRANT_x: combinational pass-through, no added latency.
//    - ds_out=ds_in_x; ds_out_valid=ds_in_x_valid; ds_out_source=x.
//    - ds_in_x_next_data=ds_out_next_data; the other input's next_data=0.
//  - Release: on an output transfer with ds_out_last=1.
//    - Go to IDLE, set last_grant<=x, clear the element counter.
//    - This gives one bubble cycle between packets.
//  Element counter: width $clog2(MAX_PACKET_LEN+1), counts output transfers in the
//  current packet. When count==MAX_PACKET_LEN-1 in GRANT_x:
//  - ds_out_last=1 regardless of ds_in_x_last.
//  - A transfer at that count with ds_in_x_last=0 sets err_overlong (sticky) and
//    releases.
//  - The rest of that input is treated as a new packet at the next arbitration.
//  - An input last on exactly element MAX_PACKET_LEN is legal: no error.
//  Valid dropping mid-packet keeps the grant; there is no timeout.
//  Reset values:
//  - FSM=IDLE, last_grant=B (A wins the first tie), counter=0, err_overlong=0.
//  - All next_data=0, ds_out_valid=0, ds_out_last=0, ds_out_source=0, ds_out=0.
//  Reset mid-packet: the packet is abandoned and all the above values apply on the
//  next cycle.
//  Non-granted input valid is ignored; data must be held by the producer.
// TESTING
//  1 A alone sends 3 elems (1,2,3; last on 3); ds_out_next_data=1
//    -> out 1,2,3, source=0, last only on 3, B next_data=0 throughout.
//  2 A and B both valid from reset, each sends 2-elem packets
//    -> order A,B,A,B; exactly one idle cycle between packets.
//  3 A sends 10 elems, last on 10th, MAX_PACKET_LEN=8
//    -> out last forced on 8th, err_overlong=1; elems 9-10 form a 2nd packet.
//  4 Granted input drops valid 3 cycles mid-packet while B is valid
//    -> grant held, B next_data=0, resumes without loss.
//  5 Downstream next_data toggled with 3-cycle latency, as in the splitter benches
//    -> no duplicated or lost elements; in-order data check.
//  6 rst asserted mid-packet of B
//    -> next cycle all outputs at reset values; the next tie goes to A.

Source files
------------

// File: rtl/stream_packet_arbiter_if.sv
// Stream bundle for the two-producer packet arbiter.
// The master modport is the arbiter's view.
// The slave modport is the view of the producers and consumer around it.
interface stream_packet_arbiter_if #(
    parameter int WIDTH = 5
);
    // Producer A
    logic             ds_in_a_next_data;
    logic [WIDTH-1:0] ds_in_a;
    logic             ds_in_a_valid;
    logic             ds_in_a_last;
    // Producer B
    logic             ds_in_b_next_data;
    logic [WIDTH-1:0] ds_in_b;
    logic             ds_in_b_valid;
    logic             ds_in_b_last;
    // Downstream consumer
    logic             ds_out_next_data;
    logic [WIDTH-1:0] ds_out;
    logic             ds_out_valid;
    logic             ds_out_last;
    logic             ds_out_source;
    logic             err_overlong;

    modport master (
        output ds_in_a_next_data, input ds_in_a, input ds_in_a_valid, input ds_in_a_last,
        output ds_in_b_next_data, input ds_in_b, input ds_in_b_valid, input ds_in_b_last,
        input ds_out_next_data, output ds_out, output ds_out_valid, output ds_out_last,
        output ds_out_source, output err_overlong
    );

    modport slave (
        input ds_in_a_next_data, output ds_in_a, output ds_in_a_valid, output ds_in_a_last,
        input ds_in_b_next_data, output ds_in_b, output ds_in_b_valid, output ds_in_b_last,
        output ds_out_next_data, input ds_out, input ds_out_valid, input ds_out_last,
        input ds_out_source, input err_overlong
    );
endinterface

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter between two next_data/valid/last producers.
// The granted input is passed through combinationally until its last element transfers.
// Packets longer than MAX_PACKET_LEN are cut, and a sticky error flag is raised.
module stream_packet_arbiter #(
    parameter int WIDTH          = 5,
    parameter int MAX_PACKET_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    stream_packet_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(MAX_PACKET_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             last_grant_r;   // 0 = A was granted last, 1 = B
    logic [CNT_W-1:0] count_r;
    logic             err_r;

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic             cut_s;
    logic             xfer_s;
    logic             release_s;

    // Pick the granted producer's data, valid and last for the pass-through path.
    always_comb begin
        sel_data_s  = {WIDTH{1'b0}};
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        case (state_r)
            GRANT_A: begin
                sel_data_s  = bus.ds_in_a;
                sel_valid_s = bus.ds_in_a_valid;
                sel_last_s  = bus.ds_in_a_last;
            end
            GRANT_B: begin
                sel_data_s  = bus.ds_in_b;
                sel_valid_s = bus.ds_in_b_valid;
                sel_last_s  = bus.ds_in_b_last;
            end
            default: begin
                sel_data_s  = {WIDTH{1'b0}};
                sel_valid_s = 1'b0;
                sel_last_s  = 1'b0;
            end
        endcase
    end

    // The element at index MAX_PACKET_LEN-1 always closes the packet.
    assign cut_s     = (state_r != IDLE) && (count_r == CNT_W'(MAX_PACKET_LEN - 1));
    assign xfer_s    = sel_valid_s & bus.ds_out_next_data;
    assign release_s = xfer_s & (sel_last_s | cut_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision: round-robin on ties, hold the grant until release.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ds_in_a_valid && (!bus.ds_in_b_valid || last_grant_r)) begin
                    state_next_s = GRANT_A;
                end else if (bus.ds_in_b_valid) begin
                    state_next_s = GRANT_B;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_A, GRANT_B: begin
                if (release_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Track the element count, the round-robin history and the sticky over-length flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r      <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
            err_r        <= 1'b0;
        end else if (release_s) begin
            count_r      <= {CNT_W{1'b0}};
            last_grant_r <= (state_r == GRANT_B);
            if (cut_s && !sel_last_s) begin
                err_r <= 1'b1;
            end
        end else if (xfer_s) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Drive the handshake outputs from the current grant.
    always_comb begin
        bus.ds_in_a_next_data = 1'b0;
        bus.ds_in_b_next_data = 1'b0;
        bus.ds_out            = {WIDTH{1'b0}};
        bus.ds_out_valid      = 1'b0;
        bus.ds_out_last       = 1'b0;
        bus.ds_out_source     = 1'b0;
        case (state_r)
            GRANT_A: begin
                bus.ds_in_a_next_data = bus.ds_out_next_data;
                bus.ds_out            = sel_data_s;
                bus.ds_out_valid      = sel_valid_s;
                bus.ds_out_last       = sel_last_s | cut_s;
                bus.ds_out_source     = 1'b0;
            end
            GRANT_B: begin
                bus.ds_in_b_next_data = bus.ds_out_next_data;
                bus.ds_out            = sel_data_s;
                bus.ds_out_valid      = sel_valid_s;
                bus.ds_out_last       = sel_last_s | cut_s;
                bus.ds_out_source     = 1'b1;
            end
            default: begin
                bus.ds_in_a_next_data = 1'b0;
                bus.ds_in_b_next_data = 1'b0;
            end
        endcase
    end

    assign bus.err_overlong = err_r;
endmodule
